nbit_vec_ser: RTL

- Downstream consumer of the lane-vector delay line: takes a VEC-lane vector of DSIZE-bit words and emits the lanes one per beat on a valid/ready stream.
- Converts the delay line's parallel lane output into a narrow serial stream for a single-lane consumer.
- Contains a one-vector holding register and a lane counter. Supports back-to-back vectors with no bubble.

---
 rtl/nbit_vec_ser.sv | 134 +++++++++++++
 1 files changed

// File: rtl/nbit_vec_ser.sv
// nbit_vec_ser: serialises a VEC-lane vector into one lane word per beat.
// Optional stall counter enabled by defining NBIT_VEC_SER_STALL_CNT_EN.
module nbit_vec_ser #(
  parameter int DSIZE     = 1,
  parameter int VEC       = 10,
  parameter int LSB_FIRST = 1,
  localparam int CW = (VEC > 1) ? $clog2(VEC) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [DSIZE-1:0] din [VEC],
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [DSIZE-1:0] dout,
  output logic [CW-1:0]    out_lane,
  output logic             out_first,
  output logic             out_last,
  output logic             busy
`ifdef NBIT_VEC_SER_STALL_CNT_EN
  ,
  input  logic             stall_clr,
  output logic [15:0]      stall_cnt
`endif
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [CW-1:0] LAST = CW'(VEC - 1);

  state_t          state, nxt_state;
  logic [CW-1:0]   cnt, nxt_cnt;
  logic [DSIZE-1:0] held [VEC];
  logic [DSIZE-1:0] nxt_held [VEC];
  logic [DSIZE-1:0] nxt_dout;
  logic [CW-1:0]   nxt_lane;
  logic            xfer, is_last, take;

  function automatic logic [CW-1:0] lane_of(input logic [CW-1:0] c);
    if (LSB_FIRST != 0) return c;
    else return LAST - c;
  endfunction

  // next-state, count and capture decisions; in_rdy is the only comb output
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_held  = held;
    xfer      = (state == SHIFT) && out_rdy;
    is_last   = (cnt == LAST);
    in_rdy    = (state == IDLE) || (xfer && is_last);
    take      = in_vld && in_rdy;
    unique case (state)
      IDLE: begin
        if (take) begin
          nxt_state = SHIFT;
          nxt_cnt   = '0;
          nxt_held  = din;
        end
      end
      SHIFT: begin
        if (xfer) begin
          if (is_last) begin
            nxt_cnt = '0;
            if (take) nxt_held = din;
            else nxt_state = IDLE;
          end else begin
            nxt_cnt = cnt + 1'b1;
          end
        end
      end
    endcase
  end

  // select the lane word that the next beat will present
  always_comb begin
    nxt_lane = lane_of(nxt_cnt);
    nxt_dout = '0;
    for (int i = 0; i < VEC; i++) begin
      if (nxt_lane == CW'(i)) nxt_dout = nxt_held[i];
    end
  end

  // state, count and holding register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      for (int i = 0; i < VEC; i++) held[i] <= '0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      held  <= nxt_held;
    end
  end

  // registered beat outputs, zeroed whenever no vector is held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld   <= 1'b0;
      dout      <= '0;
      out_lane  <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else if (nxt_state == SHIFT) begin
      out_vld   <= 1'b1;
      dout      <= nxt_dout;
      out_lane  <= nxt_lane;
      out_first <= (nxt_cnt == '0);
      out_last  <= (nxt_cnt == LAST);
      busy      <= 1'b1;
    end else begin
      out_vld   <= 1'b0;
      dout      <= '0;
      out_lane  <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end
  end

`ifdef NBIT_VEC_SER_STALL_CNT_EN
  // saturating count of cycles a beat waits on the consumer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt <= '0;
    else if (stall_clr) stall_cnt <= '0;
    else if (out_vld && !out_rdy && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule
